// File: rtl/seg_display_reader.sv
// Purpose: passive reader for a multiplexed active-low 7-segment bus; recovers debounced per-digit codes.
// Latency: pin strobe edge to sample point is 2 + SETTLE_CYC cycles; commit lands 1 cycle after the last matching sample.
// Backpressure: none; the reader only observes the bus and never stalls it.
module seg_display_reader #(
   parameter int DIGITS     = 2,
   parameter int SETTLE_CYC = 4,
   parameter int STABLE_CNT = 3,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            SEG_N,
   input  logic [DIGITS-1:0]     DIG_N,
   output logic [4*DIGITS-1:0]   CODE,
   output logic                  COLLISION,
   output logic                  ERR,
   output logic                  VALID,
   output logic                  UPDATE
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int MW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_REL} state_t;

   logic [7:0]          r_seg_s1, r_seg_s2;
   logic [DIGITS-1:0]   r_dig_s1, r_dig_s2;
   state_t              r_state, w_state_nx;
   logic [SW-1:0]       r_cnt, w_cnt_nx;
   logic [IW-1:0]       r_idx, w_idx, w_idx_nx;
   logic [CW-1:0]       w_nlow;
   logic                w_legal, w_same, w_sample, w_timeout;
   logic [3:0]          w_dec;
   logic [3:0]          r_cand [DIGITS];
   logic [MW-1:0]       r_match [DIGITS];
   logic [DIGITS-1:0]   r_done, w_commit;
   logic [4*DIGITS-1:0] r_code;
   logic                r_upd;
   logic [TW-1:0]       r_to;

   // Map a raw active-low segment pattern back to its display code.
   function automatic logic [3:0] f_decode(input logic [7:0] p);
      case (p)
         8'hC0:   f_decode = 4'h0;
         8'hF9:   f_decode = 4'h1;
         8'hA4:   f_decode = 4'h2;
         8'hB0:   f_decode = 4'h3;
         8'h99:   f_decode = 4'h4;
         8'h92:   f_decode = 4'h5;
         8'h82:   f_decode = 4'h6;
         8'hF8:   f_decode = 4'h7;
         8'h80:   f_decode = 4'h8;
         8'h90:   f_decode = 4'h9;
         8'h7F:   f_decode = 4'hA;
         8'hBF:   f_decode = 4'hF;
         8'hFF:   f_decode = 4'hB;
         8'hC6:   f_decode = 4'hC;
         default: f_decode = 4'hE;
      endcase
   endfunction

   // Two-stage synchronisers; idle level is all-high (nothing lit, no strobe).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_s1 <= 8'hFF;
         r_seg_s2 <= 8'hFF;
         r_dig_s1 <= '1;
         r_dig_s2 <= '1;
      end else begin
         r_seg_s1 <= SEG_N;
         r_seg_s2 <= r_seg_s1;
         r_dig_s1 <= DIG_N;
         r_dig_s2 <= r_dig_s1;
      end
   end

   // Strobe legality: exactly one low bit; remember which one.
   always_comb begin
      w_nlow = '0;
      w_idx  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!r_dig_s2[i]) begin
            w_nlow = w_nlow + CW'(1);
            w_idx  = IW'(i);
         end
      end
      w_legal = (w_nlow == CW'(1));
      w_same  = w_legal && (w_idx == r_idx);
      w_dec   = f_decode(r_seg_s2);
   end

   // Scan FSM next-state: wait for strobe, let it settle, take one sample, wait for release.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_idx_nx   = r_idx;
      w_sample   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_legal) begin
               w_idx_nx   = w_idx;
               w_cnt_nx   = '0;
               w_state_nx = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!w_same) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt == SW'(SETTLE_CYC - 1)) begin
               w_sample   = 1'b1;
               w_state_nx = S_WAIT_REL;
            end else begin
               w_cnt_nx = r_cnt + SW'(1);
            end
         end
         S_WAIT_REL: begin
            if (r_dig_s2[r_idx]) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Scan FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
      end
   end

   // Timeout fires once when the idle counter reaches its limit without a sample.
   assign w_timeout = !w_sample && (r_to == TW'(TIMEOUT - 1));

   // Idle timer: restarts on every sample, saturates at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_to <= '0;
      else if (w_sample)              r_to <= '0;
      else if (r_to != TW'(TIMEOUT))  r_to <= r_to + TW'(1);
   end

   // A digit commits while its match counter sits at the stability threshold.
   always_comb begin
      for (int i = 0; i < DIGITS; i++) w_commit[i] = (r_match[i] == MW'(STABLE_CNT));
   end

   // Per-digit debounce, commit and committed-flag tracking; timeout clears flags but not codes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_cand[i]  <= '0;
            r_match[i] <= '0;
         end
         r_done <= '0;
         r_code <= {DIGITS{4'hB}};
         r_upd  <= 1'b0;
      end else begin
         r_upd <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            if (w_timeout) begin
               r_match[i] <= '0;
            end else if (w_sample && (r_idx == IW'(i))) begin
               if (w_dec == r_cand[i]) begin
                  if (r_match[i] != MW'(STABLE_CNT)) r_match[i] <= r_match[i] + MW'(1);
               end else begin
                  r_cand[i]  <= w_dec;
                  r_match[i] <= MW'(1);
               end
            end
            if (w_commit[i]) begin
               r_code[4*i +: 4] <= r_cand[i];
               if (r_code[4*i +: 4] != r_cand[i]) r_upd <= 1'b1;
            end
            if (w_timeout)        r_done[i] <= 1'b0;
            else if (w_commit[i]) r_done[i] <= 1'b1;
         end
      end
   end

   // Status flags derived from the committed nibbles.
   always_comb begin
      COLLISION = 1'b0;
      ERR       = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_code[4*i +: 4] == 4'hC) COLLISION = 1'b1;
         if (r_code[4*i +: 4] == 4'hE) ERR = 1'b1;
      end
   end

   assign CODE   = r_code;
   assign VALID  = &r_done;
   assign UPDATE = r_upd;

endmodule

// File: tb/tb_seg_display_reader.sv
// Purpose: randomized and directed bench for seg_display_reader against a transaction-level model.
// Latency: model works per strobe pulse; outputs are compared a few cycles after each pulse ends.
// Backpressure: none; the bench drives the bus freely.
module tb_seg_display_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] SEG_N;
   logic [1:0] DIG_N;
   logic [7:0] CODE;
   logic       COLLISION, ERR, VALID, UPDATE;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state: one entry per digit.
   logic [3:0] m_cand [2];
   int         m_match [2];
   logic [3:0] m_code [2];
   bit         m_done [2];
   int         exp_upd;
   int         upd_cnt;
   logic [7:0] last_pat [2];

   logic [7:0] pat_tab  [16];
   bit         pat_ok   [16];
   logic [3:0] valid_codes [14];

   seg_display_reader #(.DIGITS(2), .SETTLE_CYC(4), .STABLE_CNT(3), .TIMEOUT(1000)) dut (
      .clk(clk), .rst(rst), .SEG_N(SEG_N), .DIG_N(DIG_N), .CODE(CODE),
      .COLLISION(COLLISION), .ERR(ERR), .VALID(VALID), .UPDATE(UPDATE)
   );

   always #5 clk = ~clk;

   // Count UPDATE pulses away from the active edge.
   always @(negedge clk) begin
      if (!rst && UPDATE === 1'b1) upd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] mdec(input logic [7:0] s);
      for (int c = 0; c < 16; c++) begin
         if (pat_ok[c] && pat_tab[c] == s) return 4'(c);
      end
      return 4'hE;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cand[d]  = 4'h0;
         m_match[d] = 0;
         m_code[d]  = 4'hB;
         m_done[d]  = 1'b0;
      end
      exp_upd = 0;
      upd_cnt = 0;
   endtask

   task automatic model_sample(input int d, input logic [7:0] s);
      logic [3:0] c;
      c = mdec(s);
      if (c == m_cand[d]) m_match[d] = (m_match[d] < 3) ? m_match[d] + 1 : 3;
      else begin
         m_cand[d]  = c;
         m_match[d] = 1;
      end
      if (m_match[d] == 3) begin
         if (m_code[d] != m_cand[d]) exp_upd++;
         m_code[d] = m_cand[d];
         m_done[d] = 1'b1;
      end
   endtask

   task automatic model_timeout();
      for (int d = 0; d < 2; d++) begin
         m_done[d]  = 1'b0;
         m_match[d] = 0;
      end
   endtask

   // One strobe pulse: d<0 drives an illegal both-low strobe. Long pulses yield exactly one sample.
   task automatic pulse(input int d, input logic [7:0] s, input int len, input int gap);
      logic [1:0] one;
      one = 2'b01;
      @(posedge clk); #1;
      SEG_N = s;
      DIG_N = (d < 0) ? 2'b00 : ~(one << d);
      repeat (len) @(posedge clk);
      #1 DIG_N = 2'b11;
      repeat (gap) @(posedge clk);
      if (d >= 0 && len >= 8) model_sample(d, s);
   endtask

   task automatic check_all(input string tag);
      @(negedge clk);
      chk({tag, ".code"},  32'(CODE), 32'({m_code[1], m_code[0]}));
      chk({tag, ".valid"}, 32'(VALID), 32'(m_done[0] && m_done[1]));
      chk({tag, ".coll"},  32'(COLLISION), 32'(m_code[0] == 4'hC || m_code[1] == 4'hC));
      chk({tag, ".err"},   32'(ERR), 32'(m_code[0] == 4'hE || m_code[1] == 4'hE));
      chk({tag, ".upd"},   32'(upd_cnt), 32'(exp_upd));
   endtask

   initial begin
      int d, len, gap;
      logic [7:0] s;

      pat_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h7F, 8'hFF, 8'hC6, 8'h00, 8'h00, 8'hBF};
      pat_ok  = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,1};
      valid_codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};

      rst = 1'b1; SEG_N = 8'hFF; DIG_N = 2'b11;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst.code", 32'(CODE), 32'h000000BB);
      chk("rst.valid", 32'(VALID), 32'd0);
      chk("rst.update", 32'(UPDATE), 32'd0);
      check_all("rst");

      // Three full scans of digit0=2, digit1=5.
      for (int k = 0; k < 3; k++) begin
         pulse(0, 8'hA4, 20, 4);
         check_all("scan.d0");
         pulse(1, 8'h92, 20, 4);
         check_all("scan.d1");
      end
      chk("scan.code52", 32'(CODE), 32'h00000052);
      chk("scan.updates", 32'(upd_cnt), 32'd2);

      // Strobe shorter than settle: no sample.
      pulse(0, 8'hF9, 3, 6);
      check_all("short");

      // Alternating pattern never stabilises; then collision code commits.
      for (int k = 0; k < 4; k++) begin
         pulse(0, (k % 2) ? 8'hF9 : 8'hC0, 20, 4);
         pulse(1, 8'h92, 20, 4);
      end
      check_all("alt");
      chk("alt.hold", 32'(CODE), 32'h00000052);
      for (int k = 0; k < 3; k++) pulse(0, 8'hC6, 20, 4);
      check_all("coll");
      chk("coll.flag", 32'(COLLISION), 32'd1);

      // Illegal strobe ignored; unknown pattern becomes E.
      pulse(-1, 8'h80, 50, 4);
      check_all("illegal");
      for (int k = 0; k < 3; k++) pulse(1, 8'h55, 20, 4);
      check_all("errpat");
      chk("errpat.flag", 32'(ERR), 32'd1);

      // Timeout drops VALID but holds CODE.
      chk("pre_to.valid", 32'(VALID), 32'd1);
      repeat (1010) @(posedge clk);
      model_timeout();
      check_all("timeout");
      chk("timeout.valid", 32'(VALID), 32'd0);

      // Randomized scans.
      last_pat[0] = 8'hC6;
      last_pat[1] = 8'h55;
      for (int k = 0; k < 200; k++) begin
         d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 1));
         if (d >= 0 && $urandom_range(0, 9) < 6) s = last_pat[d];
         else if ($urandom_range(0, 4) != 0) s = pat_tab[valid_codes[$urandom_range(0, 13)]];
         else s = 8'($urandom);
         if (d >= 0) last_pat[d] = s;
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(8, 25));
         gap = int'($urandom_range(4, 8));
         pulse(d, s, len, gap);
         check_all("rand");
      end

      // Reset asserted while a strobe is settling.
      @(posedge clk); #1;
      SEG_N = 8'hF9; DIG_N = 2'b10;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst.code", 32'(CODE), 32'h000000BB);
      chk("midrst.valid", 32'(VALID), 32'd0);
      chk("midrst.update", 32'(UPDATE), 32'd0);
      chk("midrst.coll", 32'(COLLISION), 32'd0);
      chk("midrst.err", 32'(ERR), 32'd0);
      DIG_N = 2'b11;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) pulse(0, 8'h99, 20, 4);
      check_all("postrst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
